// File: rtl/periph_bus_ctrl_pkg.sv
// Shared definitions for the peripheral bus controller.
//   state_t     : controller FSM encoding
//   SLV_*       : bit position of each peripheral in select/valid/ready vectors
//   NUM_SLV     : number of peripherals behind the controller
//   prio_sel()  : reduces a select vector to one hot, lowest index first
package periph_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int NUM_SLV  = 3;
    localparam int SLV_PLIC = 0;
    localparam int SLV_GPIO = 1;
    localparam int SLV_UART = 2;

    // The decoder should never assert more than one select; if it does, the
    // lowest index (PLIC, then GPIO, then UART) is the one that is served.
    function automatic logic [NUM_SLV-1:0] prio_sel(input logic [NUM_SLV-1:0] sel);
        logic [NUM_SLV-1:0] grant;
        grant = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (sel[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/periph_rdata_mux.sv
// One-hot read data multiplexer.
//   sel       : one-hot peripheral select (all zero gives zero output)
//   rdata_in  : concatenated peripheral read data, peripheral i at [i*W +: W]
//   rdata_out : read data of the selected peripheral
module periph_rdata_mux #(
    parameter int NUM = 3,
    parameter int W   = 32
) (
    input  logic [NUM-1:0]   sel,
    input  logic [NUM*W-1:0] rdata_in,
    output logic [W-1:0]     rdata_out
);

    // AND-OR structure: no priority chain, grows linearly with NUM.
    always_comb begin
        rdata_out = '0;
        for (int i = 0; i < NUM; i++) begin
            if (sel[i]) begin
                rdata_out = rdata_out | rdata_in[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Single-outstanding transaction controller between the CPU load/store port
// and the memory-mapped peripherals (PLIC, GPIO, UART).
//   clk, rst                 : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata/wstrb : CPU request, accepted while cpu_ready=1
//   cpu_ready                : controller idle and able to accept
//   cpu_rvalid/rdata/err     : one-cycle response; rdata holds between responses
//   sel_plic/gpio/uart       : one-hot selects from the external address decoder
//   periph_addr/wdata/wstrb/we : latched request, shared by all peripherals
//   <p>_valid/ready/rdata    : per-peripheral handshake and read data
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        sel_plic,
    input  logic        sel_gpio,
    input  logic        sel_uart,
    output logic [31:0] periph_addr,
    output logic [31:0] periph_wdata,
    output logic [3:0]  periph_wstrb,
    output logic        periph_we,
    output logic        plic_valid,
    output logic        gpio_valid,
    output logic        uart_valid,
    input  logic        plic_ready,
    input  logic        gpio_ready,
    input  logic        uart_ready,
    input  logic [31:0] plic_rdata,
    input  logic [31:0] gpio_rdata,
    input  logic [31:0] uart_rdata
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   sel_raw, sel_in, sel_q, ready_vec;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          rdata_q, rdata_mux;
    logic                 slv_ready, timeout_hit;

    always_comb begin
        sel_raw           = '0;
        sel_raw[SLV_PLIC] = sel_plic;
        sel_raw[SLV_GPIO] = sel_gpio;
        sel_raw[SLV_UART] = sel_uart;
        ready_vec           = '0;
        ready_vec[SLV_PLIC] = plic_ready;
        ready_vec[SLV_GPIO] = gpio_ready;
        ready_vec[SLV_UART] = uart_ready;
    end

    assign sel_in = prio_sel(sel_raw);

    // Only the latched target's ready counts; stray readies are masked here.
    assign slv_ready   = |(sel_q & ready_vec);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    periph_rdata_mux #(
        .NUM (NUM_SLV),
        .W   (32)
    ) u_rdata_mux (
        .sel       (sel_q),
        .rdata_in  ({uart_rdata, gpio_rdata, plic_rdata}),
        .rdata_out (rdata_mux)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready beats timeout when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = (|sel_in) ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                if (slv_ready) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response data register. cpu_rdata is
    // loaded on the edge that enters RESP/ERR so it is valid with cpu_rvalid
    // and then simply holds until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periph_addr  <= '0;
            periph_wdata <= '0;
            periph_wstrb <= '0;
            periph_we    <= 1'b0;
            sel_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        periph_addr  <= cpu_addr;
                        periph_wdata <= cpu_wdata;
                        periph_wstrb <= cpu_wstrb;
                        periph_we    <= cpu_we;
                        sel_q        <= sel_in;
                        cnt_q        <= '0;
                        if (!(|sel_in)) begin
                            rdata_q <= ERR_RDATA;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (slv_ready) begin
                        rdata_q <= periph_we ? 32'h0 : rdata_mux;
                    end else if (timeout_hit) begin
                        rdata_q <= ERR_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ready  = (state_q == ST_IDLE);
    assign cpu_rvalid = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign cpu_err    = (state_q == ST_ERR);
    assign cpu_rdata  = rdata_q;

    // Decoded from registered state so all valids fall as soon as rst rises.
    assign plic_valid = (state_q == ST_ACCESS) && sel_q[SLV_PLIC];
    assign gpio_valid = (state_q == ST_ACCESS) && sel_q[SLV_GPIO];
    assign uart_valid = (state_q == ST_ACCESS) && sel_q[SLV_UART];

endmodule

// File: tb/tb_periph_bus_ctrl.sv
module tb_periph_bus_ctrl;

    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        sel_plic = 1'b0, sel_gpio = 1'b0, sel_uart = 1'b0;
    logic [31:0] periph_addr, periph_wdata;
    logic [3:0]  periph_wstrb;
    logic        periph_we;
    logic        plic_valid, gpio_valid, uart_valid;
    logic [2:0]  rdy = '0;
    logic [31:0] prd [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Peripheral model: wait_cfg[i] wait-states before ready (-1 = never),
    // extra[i] is the ready level driven while that peripheral is not selected.
    int          wait_cfg [3];
    int          vcnt     [3];
    int          vhigh    [3];
    logic [2:0]  extra = '0;
    int          mism = 0;
    logic [31:0] exp_pad, exp_pwd;
    logic [3:0]  exp_pws;
    logic        exp_pwe;

    logic [32:0] sb [$];

    periph_bus_ctrl #(
        .TIMEOUT_CYC (16),
        .ERR_RDATA   (ERR_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wstrb    (cpu_wstrb),
        .cpu_ready    (cpu_ready),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .cpu_err      (cpu_err),
        .sel_plic     (sel_plic),
        .sel_gpio     (sel_gpio),
        .sel_uart     (sel_uart),
        .periph_addr  (periph_addr),
        .periph_wdata (periph_wdata),
        .periph_wstrb (periph_wstrb),
        .periph_we    (periph_we),
        .plic_valid   (plic_valid),
        .gpio_valid   (gpio_valid),
        .uart_valid   (uart_valid),
        .plic_ready   (rdy[0]),
        .gpio_ready   (rdy[1]),
        .uart_ready   (rdy[2]),
        .plic_rdata   (prd[0]),
        .gpio_rdata   (prd[1]),
        .uart_rdata   (prd[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Peripheral model plus per-cycle protocol watch while any valid is high.
    logic [2:0] vld;
    assign vld = {uart_valid, gpio_valid, plic_valid};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] === 1'b1) begin
                vhigh[i]++;
                rdy[i] = (wait_cfg[i] >= 0 && vcnt[i] == wait_cfg[i]);
                vcnt[i]++;
            end else begin
                vcnt[i] = 0;
                rdy[i]  = extra[i];
            end
        end
        if (|vld) begin
            if (periph_addr !== exp_pad || periph_wdata !== exp_pwd ||
                periph_wstrb !== exp_pws || periph_we !== exp_pwe ||
                cpu_ready !== 1'b0 || $countones(vld) != 1) begin
                mism++;
            end
        end
    end

    // Scoreboard: every response popped and compared against what was queued.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst === 1'b0 && cpu_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", cpu_rdata, e[31:0]);
                chk("resp_err", {31'd0, cpu_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [2:0] sel,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input bit push, input bit hold, output int acc);
        int n = 0;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        {sel_uart, sel_gpio, sel_plic} = sel;
        while (cpu_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("accept_wait_expired", 32'd0, 32'd1);
        acc     = cyc;
        exp_pad = a;
        exp_pwd = wd;
        exp_pws = ws;
        exp_pwe = we;
        if (push) sb.push_back({exp_err, exp_rd});
        @(negedge clk);
        if (!hold) begin
            cpu_req = 1'b0;
            {sel_uart, sel_gpio, sel_plic} = 3'b000;
        end
    endtask

    task automatic wait_rv(output int c);
        int n = 0;
        while (cpu_rvalid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("rvalid_wait_expired", 32'd0, 32'd1);
        c = cyc;
    endtask

    initial begin
        int acc, acc2, rv, rv2, vh0;
        for (int i = 0; i < 3; i++) begin
            wait_cfg[i] = 0;
            vcnt[i]     = 0;
            vhigh[i]    = 0;
            prd[i]      = 32'h0;
        end
        exp_pad = '0; exp_pwd = '0; exp_pws = '0; exp_pwe = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_valids", {29'd0, vld}, 32'd0);
        chk("rst_periph_addr", periph_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // GPIO read, zero wait; a stray gpio ready while idle is ignored
        extra       = 3'b010;
        @(negedge clk);
        extra       = 3'b000;
        prd[1]      = 32'hA5A5_0001;
        wait_cfg[1] = 0;
        mism        = 0;
        vh0         = vhigh[1];
        issue(32'h4000_0010, 1'b0, 32'h0, 4'h0, 3'b010, 32'hA5A5_0001, 1'b0, 1, 0, acc);
        wait_rv(rv);
        chk("gpio_latency", rv - acc, 32'd2);
        @(negedge clk);
        chk("gpio_rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);
        chk("gpio_rdata_hold", cpu_rdata, 32'hA5A5_0001);
        chk("gpio_valid_cycles", vhigh[1] - vh0, 32'd1);
        chk("gpio_protocol", mism, 32'd0);

        // UART write, 3 wait-states
        prd[2]      = 32'h7777_7777;
        wait_cfg[2] = 3;
        mism        = 0;
        vh0         = vhigh[2];
        issue(32'h6000_0004, 1'b1, 32'h41, 4'b0001, 3'b100, 32'h0, 1'b0, 1, 0, acc);
        wait_rv(rv);
        chk("uart_latency", rv - acc, 32'd5);
        @(negedge clk);
        chk("uart_valid_cycles", vhigh[2] - vh0, 32'd4);
        chk("uart_protocol", mism, 32'd0);

        // Unmapped read
        vh0 = vhigh[0] + vhigh[1] + vhigh[2];
        issue(32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'b000, ERR_VAL, 1'b1, 1, 0, acc);
        wait_rv(rv);
        chk("unmapped_latency", rv - acc, 32'd1);
        @(negedge clk);
        chk("unmapped_no_valid", vhigh[0] + vhigh[1] + vhigh[2] - vh0, 32'd0);
        chk("unmapped_ready_back", {31'd0, cpu_ready}, 32'd1);

        // PLIC read that never completes -> timeout
        prd[0]      = 32'h1234_5678;
        wait_cfg[0] = -1;
        mism        = 0;
        vh0         = vhigh[0];
        issue(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'b001, ERR_VAL, 1'b1, 1, 0, acc);
        wait_rv(rv);
        chk("timeout_latency", rv - acc, 32'd17);
        chk("timeout_ready_low_in_err", {31'd0, cpu_ready}, 32'd0);
        @(negedge clk);
        chk("timeout_ready_back", {31'd0, cpu_ready}, 32'd1);
        chk("timeout_valid_cycles", vhigh[0] - vh0, 32'd16);
        chk("timeout_protocol", mism, 32'd0);

        // Reset during the 2nd ACCESS cycle of a GPIO access
        wait_cfg[1] = -1;
        prd[1]      = 32'hBAD0_BAD0;
        issue(32'h4000_0020, 1'b0, 32'h0, 4'h0, 3'b010, 32'h0, 1'b0, 0, 0, acc);
        @(negedge clk);
        chk("midrst_valid_before", {31'd0, gpio_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gpio_valid", {31'd0, gpio_valid}, 32'd0);
        chk("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("midrst_periph_addr", periph_addr, 32'd0);
        chk("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wait_cfg[1] = 0;
        prd[1]      = 32'h0BAD_F00D;
        issue(32'h4000_0030, 1'b0, 32'h0, 4'h0, 3'b010, 32'h0BAD_F00D, 1'b0, 1, 0, acc);
        wait_rv(rv);
        chk("postrst_latency", rv - acc, 32'd2);
        @(negedge clk);

        // Back-to-back GPIO then PLIC with request held; foreign readies high
        prd[1]      = 32'h1111_2222;
        prd[0]      = 32'h3333_4444;
        wait_cfg[0] = 0;
        wait_cfg[1] = 0;
        extra       = 3'b101;
        issue(32'h4000_0040, 1'b0, 32'h0, 4'h0, 3'b010, 32'h1111_2222, 1'b0, 1, 1, acc);
        wait_rv(rv);
        extra = 3'b000;
        issue(32'h3000_0008, 1'b0, 32'h0, 4'h0, 3'b001, 32'h3333_4444, 1'b0, 1, 0, acc2);
        chk("b2b_accept_after_rvalid", acc2 - rv, 32'd1);
        wait_rv(rv2);
        chk("b2b_second_latency", rv2 - acc2, 32'd2);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
